// File: rtl/mod_mul64_module_pkg.sv
// mod_mul64_module_pkg: shared FSM encoding and counter sizing for the modular multiplier
package mod_mul64_module_pkg;
  typedef enum logic [1:0] {IDLE, RED, MUL, FIN} state_t;
  function automatic int cnt_w(input int a, input int b);
    return ((a > b) ? a : b) > 1 ? $clog2((a > b) ? a : b) : 1;
  endfunction
endpackage

// File: rtl/mod_dbl_add_red.sv
// mod_dbl_add_red: computes 2r+addend and reduces it by up to two subtractions of n
module mod_dbl_add_red #(
  parameter int W = 66
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] addend,
  input  logic [W-1:0] n,
  output logic [W-1:0] y
);
  logic [W-1:0] t, n2;
  // t < 3n whenever r < n and addend < n, so two compares against n and 2n suffice
  always_comb begin
    t = (r << 1) + addend;
    n2 = n << 1;
    y = (t >= n2) ? t - n2 : (t >= n) ? t - n : t;
  end
endmodule

// File: rtl/mod_mul64_module.sv
// mod_mul64_module: bit-serial interleaved modular multiplier P = (A*B) mod N
module mod_mul64_module
  import mod_mul64_module_pkg::*;
#(
  parameter int A_WIDTH = 64,
  parameter int B_WIDTH = 64,
  parameter int N_WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  input  logic [N_WIDTH-1:0] N,
  output logic [N_WIDTH-1:0] P,
  output logic               done
);
  localparam int W = N_WIDTH + 2;
  localparam int CW = cnt_w(A_WIDTH, B_WIDTH);
  state_t st, nxt;
  logic [A_WIDTH-1:0] a_r;
  logic [B_WIDTH-1:0] b_r;
  logic [N_WIDTH-1:0] n_r, bm;
  logic [W-1:0] r, addend, y;
  logic [CW-1:0] cnt;
  logic last;
  mod_dbl_add_red #(.W(W)) u_red (
    .r(r),
    .addend(addend),
    .n(W'(n_r)),
    .y(y)
  );
  // next-state: RED and MUL each run until the bit counter reaches zero
  always_comb begin
    last = (cnt == '0);
    addend = (st == RED) ? W'(b_r[cnt]) : (a_r[cnt] ? W'(bm) : '0);
    nxt = st;
    nxt = (st == IDLE) ? (start ? RED : IDLE) :
          (st == RED)  ? (last ? MUL : RED) :
          (st == MUL)  ? (last ? FIN : MUL) : IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else st <= nxt;
  end
  // datapath: operand capture, B pre-reduction, interleaved multiply, result publish
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r <= '0;
      b_r <= '0;
      n_r <= '0;
      bm <= '0;
      r <= '0;
      cnt <= '0;
      P <= '0;
      done <= 1'b0;
    end else begin
      done <= (st == FIN);
      if (st == IDLE && start) begin
        a_r <= A;
        b_r <= B;
        n_r <= N;
        r <= '0;
        cnt <= CW'(B_WIDTH - 1);
      end else if (st == RED) begin
        r <= last ? '0 : y;
        bm <= last ? y[N_WIDTH-1:0] : bm;
        cnt <= last ? CW'(A_WIDTH - 1) : cnt - 1'b1;
      end else if (st == MUL) begin
        r <= y;
        cnt <= cnt - 1'b1;
      end else if (st == FIN) begin
        P <= (n_r == '0) ? '0 : r[N_WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_mod_mul64_module.sv
// tb_mod_mul64_module: table-driven and scoreboard checks of the modular multiplier
module tb_mod_mul64_module;
  logic clk = 1'b0;
  logic rst, start;
  logic [63:0] A, B, N, P;
  logic done;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [63:0] a, b, n, p;
  } vec_t;
  vec_t tv[$];
  logic [63:0] exp_q[$];

  mod_mul64_module dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .A(A),
    .B(B),
    .N(N),
    .P(P),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [63:0] a, b, n);
    logic [127:0] am, bm2;
    if (n == 64'd0) return 64'd0;
    am = 128'(a % n);
    bm2 = 128'(b % n);
    return 64'((am * bm2) % 128'(n));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [63:0] a, b, n, p, input bit poke);
    int cyc;
    logic [63:0] e;
    @(negedge clk);
    A = a;
    B = b;
    N = n;
    start = 1'b1;
    exp_q.push_back(p);
    @(negedge clk);
    start = 1'b0;
    A = {$urandom, $urandom};
    B = {$urandom, $urandom};
    N = {$urandom, $urandom};
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = (poke && cyc == 10);
    end
    start = 1'b0;
    chk("latency", 64'(cyc), 64'd129);
    e = exp_q.pop_front();
    chk("P", P, e);
    @(negedge clk);
    chk("done_drop", 64'(done), 64'd0);
    chk("P_hold", P, e);
  endtask

  initial begin
    int cnt_done;
    logic [63:0] ra, rb, rn;
    tv.push_back('{64'd1, 64'd2, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000002});
    tv.push_back('{64'h1234567812345678, 64'h1234567812345678, 64'hFFFFFFFFFFFFFFFF, 64'h3e807e383e807e38});
    tv.push_back('{64'h8765432187654321, 64'h1234567812345678, 64'hFFFFFFFFFFFFFFFF, 64'hf4b2b4faf4b2b4fa});
    tv.push_back('{64'h8765432187654321, 64'h1234567812345678, 64'h0034567812345678, 64'h0021cd8ba5c11338});
    tv.push_back('{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0000000012345678, 64'h000000000147c1e9});
    tv.push_back('{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'd0, 64'd0});
    tv.push_back('{64'h1234567812345678, 64'h8765432187654321, 64'd1, 64'd0});
    tv.push_back('{64'd0, 64'h8765432187654321, 64'hFFFFFFFFFFFFFFC5, 64'd0});
    tv.push_back('{64'h8765432187654321, 64'd0, 64'hFFFFFFFFFFFFFFC5, 64'd0});
    rst = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    N = '0;
    repeat (3) @(negedge clk);
    chk("reset_P", P, 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    rst = 1'b1;
    foreach (tv[i]) run_op(tv[i].a, tv[i].b, tv[i].n, tv[i].p, 1'b0);
    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rn = (i < 3) ? {$urandom, $urandom} : 64'($urandom_range(2, 1000));
      run_op(ra, rb, rn, model(ra, rb, rn), 1'b0);
    end
    run_op(tv[2].a, tv[2].b, tv[2].n, tv[2].p, 1'b1);
    @(negedge clk);
    A = 64'h1234567812345678;
    B = 64'h1234567812345678;
    N = 64'hFFFFFFFFFFFFFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (80) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_P", P, 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    cnt_done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    chk("abort_no_done", 64'(cnt_done), 64'd0);
    chk("abort_P_after", P, 64'd0);
    run_op(tv[1].a, tv[1].b, tv[1].n, tv[1].p, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
